// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Optional macro BIN_TO_BCD_SEQ_BLANK_EN turns leading zero digits into 4'hF.
module bin_to_bcd_seq #(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  function automatic logic [63:0] max_val();
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < DIGITS; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_val();

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  // Saturate on overflow; optionally blank leading zeros (ones digit always kept).
  function automatic logic [BCD_W-1:0] finalize(input logic [BCD_W-1:0] s,
                                                 input logic ovf);
    logic [BCD_W-1:0] r;
    logic             seen;
    r = s;
    if (ovf) begin
      for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'h9;
    end else begin
`ifdef BIN_TO_BCD_SEQ_BLANK_EN
      seen = 1'b0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (!seen && r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
        else seen = 1'b1;
      end
`else
      seen = 1'b0;
`endif
    end
    return r;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [IN_W-1:0]       sh_q, sh_d;
  logic [BCD_W-1:0]      scr_q, scr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [BCD_W-1:0]      digits_q, digits_d;
  logic                  overflow_q, overflow_d;
  logic [BCD_W+IN_W-1:0] shifted;

  assign shifted = {add3(scr_q), sh_q} << 1;

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_d    = bin;
          scr_d   = '0;
          cnt_d   = CNT_W'(IN_W);
          ovf_d   = (64'(bin) > MAX_VAL);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {scr_d, sh_d} = shifted;
        cnt_d         = cnt_q - 1'b1;
        // Outputs are loaded on the final shift edge so they are valid alongside done.
        if (cnt_q == CNT_W'(1)) begin
          digits_d   = finalize(shifted[BCD_W+IN_W-1 -: BCD_W], ovf_q);
          overflow_d = ovf_q;
          state_d    = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == S_SHIFT);
  assign done     = (state_q == S_DONE);
  assign digits   = digits_q;
  assign overflow = overflow_q;

endmodule
